// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I/D requester and memory bus signals shared by mem_arbiter
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                i_req;
   logic [ADDR_W-1:0]   i_addr;
   logic                i_gnt;
   logic                i_rvalid;
   logic [DATA_W-1:0]   i_rdata;
   logic                d_req;
   logic                d_we;
   logic [DATA_W/8-1:0] d_be;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_gnt;
   logic                d_rvalid;
   logic [DATA_W-1:0]   d_rdata;
   logic                d_stall;
   logic                m_req;
   logic                m_we;
   logic [DATA_W/8-1:0] m_be;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic                m_gnt;
   logic                m_rvalid;
   logic [DATA_W-1:0]   m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_stall,
             m_req, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_stall,
             m_req, m_we, m_be, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding I/D memory bus arbiter, D priority
// MEM_ARB_FAIR_EN adds a starvation counter that forces I ahead after STARVE_MAX D grants.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_ARB_FAIR_EN
   , parameter int STARVE_MAX = 4
`endif
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  bus
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;   // 1 = D owns the outstanding transfer
   logic                m_we_q, m_we_d;
   logic [BE_W-1:0]     m_be_q, m_be_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic                grant_i, grant_d, done, force_i;

`ifdef MEM_ARB_FAIR_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign force_i = bus.i_req && (starve_cnt_q == CNT_W'(STARVE_MAX));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_i) begin
         starve_cnt_d = '0;
      end else if (grant_d && bus.i_req && starve_cnt_q != CNT_W'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign force_i = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      m_we_d    = m_we_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req && !force_i) begin
               grant_d   = 1'b1;
               owner_d   = 1'b1;
               m_we_d    = bus.d_we;
               m_be_d    = bus.d_be;
               m_addr_d  = bus.d_addr;
               m_wdata_d = bus.d_wdata;
               state_d   = REQ;
            end else if (bus.i_req) begin
               grant_i   = 1'b1;
               owner_d   = 1'b0;
               m_we_d    = 1'b0;
               m_be_d    = '1;
               m_addr_d  = bus.i_addr;
               m_wdata_d = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            // A response arriving with the accept completes the transfer at once.
            if (bus.m_gnt) begin
               if (bus.m_rvalid) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (bus.m_rvalid) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_be_q    <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
      end
   end

   assign bus.i_gnt    = grant_i;
   assign bus.d_gnt    = grant_d;
   assign bus.i_rvalid = done && !owner_q;
   assign bus.d_rvalid = done && owner_q;
   assign bus.i_rdata  = (done && !owner_q) ? bus.m_rdata : '0;
   assign bus.d_rdata  = (done && owner_q) ? bus.m_rdata : '0;
   assign bus.d_stall  = bus.d_req && !(done && owner_q);
   assign bus.m_req    = (state_q == REQ);
   assign bus.m_we     = m_we_q;
   assign bus.m_be     = m_be_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W = DATA_W / 8;
   localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit              d;
      bit              we;
      logic [BE_W-1:0] be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } txn_t;

   txn_t held = '{d: 1'b0, we: 1'b0, be: '0, addr: '0, wdata: '0};
   txn_t pend[$];
   bit   accepted = 1'b0;
   int   starve = 0;

   // 0 = no grant, 1 = I, 2 = D, for the current inputs
   function automatic int pick();
      if (pend.size() != 0) return 0;
      if (bus.d_req && !(FAIR && bus.i_req && starve >= STARVE_MAX)) return 2;
      if (bus.i_req) return 1;
      return 0;
   endfunction

   function automatic bit completes();
      return pend.size() != 0 && bus.m_rvalid && (accepted || bus.m_gnt);
   endfunction

   int cp;
   bit cc, cd, busy;
   always @(negedge clk) begin
      if (chk_en) begin
         cp   = pick();
         cc   = completes();
         cd   = cc && pend[0].d;
         busy = pend.size() != 0;
         chk("i_gnt", bus.i_gnt, cp == 1);
         chk("d_gnt", bus.d_gnt, cp == 2);
         chk("i_rvalid", bus.i_rvalid, cc && !cd);
         chk("d_rvalid", bus.d_rvalid, cd);
         chk("i_rdata", bus.i_rdata, (cc && !cd) ? bus.m_rdata : '0);
         chk("d_rdata", bus.d_rdata, cd ? bus.m_rdata : '0);
         chk("m_req", bus.m_req, busy && !accepted);
         chk("m_we", bus.m_we, held.we);
         chk("m_be", bus.m_be, held.be);
         chk("m_addr", bus.m_addr, held.addr);
         chk("m_wdata", bus.m_wdata, held.wdata);
         chk("d_stall", bus.d_stall, bus.d_req && !cd);
      end
   end

   int mg;
   bit mc;
   always @(posedge clk) begin
      if (!rst_n) begin
         pend.delete();
         accepted = 1'b0;
         held     = '{d: 1'b0, we: 1'b0, be: '0, addr: '0, wdata: '0};
         starve   = 0;
      end else begin
         mg = pick();
         mc = completes();
         if (mc) begin
            pend.delete();
            accepted = 1'b0;
         end else if (pend.size() != 0 && !accepted && bus.m_gnt) begin
            accepted = 1'b1;
         end
         if (mg == 2) begin
            held = '{d: 1'b1, we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
            pend.push_back(held);
            if (bus.i_req && starve < STARVE_MAX) starve++;
         end else if (mg == 1) begin
            held = '{d: 1'b0, we: 1'b0, be: {BE_W{1'b1}}, addr: bus.i_addr, wdata: '0};
            pend.push_back(held);
            starve = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
   endtask

   int order[6];
   int exp_order[6];
   int n;

   initial begin
      quiet();
      rst_n = 0;
      tick();
      chk_en = 1'b1;
      tick();
      rst_n = 1;
      #3;
      chk("reset m_req", bus.m_req, 1'b0);
      chk("reset m_addr", bus.m_addr, 32'h0);
      chk("reset m_be", bus.m_be, 4'h0);
      chk("reset gnt", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, 4'h0);

      // single fetch
      tick();
      bus.i_req = 1; bus.i_addr = 32'h100; #3;
      chk("fetch i_gnt", bus.i_gnt, 1'b1);
      tick();
      bus.i_req = 0; bus.m_gnt = 1; #3;
      chk("fetch m_req", bus.m_req, 1'b1);
      chk("fetch m_addr", bus.m_addr, 32'h100);
      chk("fetch m_be", bus.m_be, 4'hF);
      tick();
      bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h13; #3;
      chk("fetch i_rvalid", bus.i_rvalid, 1'b1);
      chk("fetch i_rdata", bus.i_rdata, 32'h13);
      tick();
      bus.m_rvalid = 0; #3;
      chk("fetch idle m_req", bus.m_req, 1'b0);

      // simultaneous requests, D wins
      tick();
      bus.i_req = 1; bus.i_addr = 32'h200;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h3; #3;
      chk("sim d_gnt", {bus.d_gnt, bus.i_gnt}, 2'b10);
      tick();
      bus.d_req = 0; bus.m_gnt = 1; #3;
      chk("sim m_we", bus.m_we, 1'b1);
      chk("sim m_addr", bus.m_addr, 32'h2000);
      chk("sim m_wdata", bus.m_wdata, 32'hDEADBEEF);
      chk("sim m_be", bus.m_be, 4'h3);
      tick();
      bus.m_gnt = 0; bus.m_rvalid = 1; #3;
      chk("sim d_rvalid", {bus.d_rvalid, bus.i_gnt}, 2'b10);
      tick();
      bus.m_rvalid = 0; #3;
      chk("sim i_gnt after idle", bus.i_gnt, 1'b1);
      tick();
      bus.i_req = 0; bus.m_gnt = 1; bus.m_rvalid = 1; bus.m_rdata = 32'hA5; #3;
      chk("sim i_rvalid", bus.i_rvalid, 1'b1);
      tick();
      quiet();

      // bus backpressure
      tick();
      bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
      tick();
      for (int k = 0; k < 5; k++) begin
         #3;
         chk("bp m_req", bus.m_req, 1'b1);
         chk("bp m_addr", bus.m_addr, 32'h40);
         chk("bp m_wdata", bus.m_wdata, 32'h1234);
         chk("bp d_stall", bus.d_stall, 1'b1);
         tick();
      end
      bus.m_gnt = 1;
      tick();
      bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h7; #3;
      chk("bp d_rvalid", {bus.d_rvalid, bus.d_stall}, 2'b10);
      bus.d_req = 0;
      tick();
      quiet();

      // starvation
      tick();
      bus.i_req = 1; bus.i_addr = 32'h300; bus.d_req = 1; bus.d_addr = 32'h3000;
      n = 0;
      for (int k = 0; k < 60 && n < 6; k++) begin
         bus.m_gnt = 1; bus.m_rvalid = 1; #3;
         if (bus.d_gnt) order[n++] = 2;
         else if (bus.i_gnt) order[n++] = 1;
         tick();
      end
`ifdef MEM_ARB_FAIR_EN
      exp_order = '{2, 2, 2, 2, 1, 2};
`else
      exp_order = '{2, 2, 2, 2, 2, 2};
`endif
      chk("starve grants seen", n, 6);
      for (int k = 0; k < 6; k++) chk($sformatf("starve grant %0d", k), order[k], exp_order[k]);
      bus.i_req = 0; bus.d_req = 0;
      tick();
      quiet();
      tick();

      // reset while in RESP
      bus.i_req = 1; bus.i_addr = 32'h500;
      tick();
      bus.i_req = 0; bus.m_gnt = 1;
      tick();
      bus.m_gnt = 0; rst_n = 0;
      tick();
      rst_n = 1; bus.m_rvalid = 1; bus.m_rdata = 32'h99; #3;
      chk("rst rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
      chk("rst m_req", bus.m_req, 1'b0);
      chk("rst m_addr", bus.m_addr, 32'h0);
      tick();
      quiet();

      // same-cycle gnt and rvalid
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80; bus.d_be = 4'hF;
      tick();
      bus.d_req = 0; bus.m_gnt = 1; bus.m_rvalid = 1; bus.m_rdata = 32'h55; #3;
      chk("same d_rvalid", bus.d_rvalid, 1'b1);
      chk("same d_rdata", bus.d_rdata, 32'h55);
      tick();
      quiet(); #3;
      chk("same idle m_req", bus.m_req, 1'b0);
      tick();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst_n        = ($urandom_range(0, 199) != 0);
         bus.i_req    = $urandom_range(0, 1);
         bus.i_addr   = $urandom;
         bus.d_req    = $urandom_range(0, 1);
         bus.d_we     = $urandom_range(0, 1);
         bus.d_be     = BE_W'($urandom);
         bus.d_addr   = $urandom;
         bus.d_wdata  = $urandom;
         bus.m_gnt    = $urandom_range(0, 1);
         bus.m_rvalid = ($urandom_range(0, 9) < 4);
         bus.m_rdata  = $urandom;
         tick();
      end
      rst_n = 1;
      quiet();
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
